// File: rtl/bitop_arbiter_pkg.sv
// Shared constants for the bitwise-operation arbiter: opcodes, FSM encodings, requester count.
// Also carries the round-robin search helper used by the arbiter top.
package bitop_arbiter_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] opcode_t;
    typedef logic [1:0] state_t;

    localparam opcode_t OP_AND  = 2'b00;
    localparam opcode_t OP_OR   = 2'b01;
    localparam opcode_t OP_XOR  = 2'b10;
    localparam opcode_t OP_NAND = 2'b11;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // First set request at or after 'start', wrapping 3 -> 0. Caller qualifies with |req.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bitop_unit.sv
// Purpose: shared combinational AND/OR/XOR/NAND unit built from gate primitives.
// Latency: purely combinational; the arbiter waits SETTLE cycles before sampling y.
// Backpressure: none; inputs come only from the arbiter's holding registers.
module bitop_unit
    import bitop_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_or;
    logic [WIDTH-1:0] y_xor;
    logic [WIDTH-1:0] y_nand;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and  u_and  (y_and[i],  a[i], b[i]);
        or   u_or   (y_or[i],   a[i], b[i]);
        xor  u_xor  (y_xor[i],  a[i], b[i]);
        nand u_nand (y_nand[i], a[i], b[i]);
    end

    always_comb begin
        y = y_and;
        case (op)
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_XOR:  y = y_xor;
            OP_NAND: y = y_nand;
            default: y = y_and;
        endcase
    end

endmodule

// File: rtl/bitop_arbiter.sv
// Purpose: 4-way arbiter for one shared bitop unit; BITOP_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: ack rises exactly SETTLE edges after the grant edge; one IDLE cycle separates operations.
// Backpressure: requesters hold req until ack; requests seen while busy wait for the next IDLE.
module bitop_arbiter
    import bitop_arbiter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]      ack,
    output logic [WIDTH-1:0]     result,
    output logic [1:0]           gnt_id,
    output logic                 busy
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       cnt;
    opcode_t          hold_op;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;
    logic [WIDTH-1:0] unit_y;
    logic [1:0]       start;
    logic [1:0]       pick;

`ifdef BITOP_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (state == ST_DONE) begin
            ptr <= gnt_id + 2'd1;
        end
    end

    assign start = ptr;
`endif

    assign pick = rr_pick(req, start);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ack     <= '0;
            result  <= '0;
            gnt_id  <= 2'd0;
            hold_op <= OP_AND;
            hold_a  <= '0;
            hold_b  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        state   <= ST_SETTLE;
                        gnt_id  <= pick;
                        hold_op <= op[int'(pick)*2 +: 2];
                        hold_a  <= a_bus[int'(pick)*WIDTH +: WIDTH];
                        hold_b  <= b_bus[int'(pick)*WIDTH +: WIDTH];
                        cnt     <= SETTLE_LD;
                    end
                end
                ST_SETTLE: begin
                    // Unit output is only trusted once the counter has drained.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state  <= ST_DONE;
                        result <= unit_y;
                        ack    <= NREQ'(1) << gnt_id;
                    end
                end
                ST_DONE: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bitop_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .a  (hold_a),
        .b  (hold_b),
        .op (hold_op),
        .y  (unit_y)
    );

endmodule
